// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet framer: parser states, opcodes, error codes.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        S_OPCODE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_DRAIN
    } pkt_state_e;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_LENGTH  = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_e;

    function automatic logic opcode_valid(input logic [7:0] op);
        return op inside {OP_ECHO, OP_ADD, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// One-entry valid/ready payload holding register; flags a push that finds it
// full and not draining.
module pkt_out_reg
    import uart_pkt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    input  logic       flush_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       last_o,
    output logic       overrun_o
);

    logic       valid_q;
    logic [7:0] data_q;
    logic       last_q;
    logic       load;

    assign overrun_o = push_i && valid_q && !ready_i;
    assign load      = push_i && (!valid_q || ready_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/uart_pkt_parser.sv
// Receive-side packet framer: decodes the 4-byte header and streams payload.
// Optional idle timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter int MaxLen        = 16,
    parameter int LenW          = 16,
    parameter int TimeoutCycles = 5560
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_valid_i,
    output logic            hdr_valid_o,
    output logic [7:0]      opcode_o,
    output logic [LenW-1:0] length_o,
    output logic [7:0]      pld_data_o,
    output logic            pld_valid_o,
    input  logic            pld_ready_i,
    output logic            pld_last_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [1:0]      err_code_o
);

    localparam logic [LenW-1:0] MAX_L = LenW'(MaxLen);
    localparam logic [LenW-1:0] ONE   = LenW'(1);

    pkt_state_e      state_q, state_d;
    logic [7:0]      op_tmp_q, op_tmp_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [LenW-1:0] length_q, length_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic            hdr_q, hdr_d;
    logic            err_q, err_d;
    err_code_e       code_q, code_d;
    logic [LenW-1:0] len_full;
    logic            push, last, flush, overrun;

    assign len_full = LenW'({rx_data_i, len_lo_q});
    assign busy_o   = (state_q != S_OPCODE);

`ifdef UART_PKT_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic        timeout;

    always_comb begin
        timeout = busy_o && !rx_valid_i && (idle_q == 16'(TimeoutCycles - 1));
        idle_d  = (!busy_o || rx_valid_i || timeout) ? 16'd0 : idle_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) idle_q <= 16'd0;
        else        idle_q <= idle_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_tmp_d = op_tmp_q;
        len_lo_d = len_lo_q;
        opcode_d = opcode_q;
        length_d = length_q;
        cnt_d    = cnt_q;
        hdr_d    = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        push     = 1'b0;
        last     = 1'b0;
        flush    = 1'b0;
        if (rx_valid_i) begin
            unique case (state_q)
                S_OPCODE: begin
                    op_tmp_d = rx_data_i;
                    state_d  = S_RSVD;
                end
                S_RSVD:   state_d = S_LEN_LO;
                S_LEN_LO: begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN_HI;
                end
                S_LEN_HI: begin
                    cnt_d = len_full;
                    if (!opcode_valid(op_tmp_q)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_OPCODE;
                        state_d = (len_full != '0) ? S_DRAIN : S_OPCODE;
                    end else if (len_full > MAX_L) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LENGTH;
                        state_d = S_DRAIN;
                    end else begin
                        hdr_d    = 1'b1;
                        opcode_d = op_tmp_q;
                        length_d = len_full;
                        state_d  = (len_full == '0) ? S_OPCODE : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    push  = 1'b1;
                    last  = (cnt_q == ONE);
                    cnt_d = cnt_q - ONE;
                    if (overrun) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVERRUN;
                    end
                    if (cnt_q == ONE) state_d = S_OPCODE;
                end
                S_DRAIN: begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) state_d = S_OPCODE;
                end
                default: state_d = S_OPCODE;
            endcase
        end
`ifdef UART_PKT_TIMEOUT_EN
        if (timeout) begin
            state_d = S_OPCODE;
            flush   = 1'b1;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_OPCODE;
            op_tmp_q <= 8'h00;
            len_lo_q <= 8'h00;
            opcode_q <= 8'h00;
            length_q <= '0;
            cnt_q    <= '0;
            hdr_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_TIMEOUT;
        end else begin
            state_q  <= state_d;
            op_tmp_q <= op_tmp_d;
            len_lo_q <= len_lo_d;
            opcode_q <= opcode_d;
            length_q <= length_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    pkt_out_reg u_out (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .data_i    (rx_data_i),
        .last_i    (last),
        .flush_i   (flush),
        .ready_i   (pld_ready_i),
        .valid_o   (pld_valid_o),
        .data_o    (pld_data_o),
        .last_o    (pld_last_o),
        .overrun_o (overrun)
    );

    assign hdr_valid_o = hdr_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign opcode_o    = opcode_q;
    assign length_o    = length_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: header decode, payload, errors, reset.
module tb_uart_pkt_parser;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        pld_ready_i = 1'b1;
    logic        hdr_valid_o, pld_valid_o, pld_last_o, busy_o, err_o;
    logic [7:0]  opcode_o, pld_data_o;
    logic [15:0] length_o;
    logic [1:0]  err_code_o;

    int tests = 0;
    int fails = 0;

    int         hdr_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] mon_op = 8'h00;
    logic [15:0] mon_len = 16'h0;
    logic [1:0] mon_code = 2'd0;
    logic [8:0] beats[$];

    uart_pkt_parser dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .hdr_valid_o (hdr_valid_o),
        .opcode_o    (opcode_o),
        .length_o    (length_o),
        .pld_data_o  (pld_data_o),
        .pld_valid_o (pld_valid_o),
        .pld_ready_i (pld_ready_i),
        .pld_last_o  (pld_last_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (hdr_valid_o) begin
                hdr_cnt = hdr_cnt + 1;
                mon_op  = opcode_o;
                mon_len = length_o;
            end
            if (err_o) begin
                err_cnt  = err_cnt + 1;
                mon_code = err_code_o;
            end
            if (hdr_valid_o && err_o) both_cnt = both_cnt + 1;
            if (pld_valid_o && pld_ready_i) beats.push_back({pld_last_o, pld_data_o});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        hdr_cnt = 0;
        err_cnt = 0;
        beats.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #12;
        check("rst_hdr", hdr_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_pvalid", pld_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_len", length_o, 0);
        rst_i = 1'b1;
        idle(2);

        // Echo packet, length 3
        clear_mon();
        send(8'hEC); send(8'h00); send(8'h03); send(8'h00);
        check("p1_hdr_pulse", hdr_valid_o, 1);
        send(8'h11);
        check("p1_pvalid_lat", pld_valid_o, 1);
        check("p1_pdata_lat", pld_data_o, 8'h11);
        send(8'h22); send(8'h33);
        idle(3);
        check("p1_hdr_cnt", hdr_cnt, 1);
        check("p1_op", mon_op, 8'hEC);
        check("p1_len", mon_len, 3);
        check("p1_nbeats", beats.size(), 3);
        if (beats.size() == 3) begin
            check("p1_b0", beats[0], 9'h011);
            check("p1_b1", beats[1], 9'h022);
            check("p1_b2", beats[2], 9'h133);
        end
        check("p1_err", err_cnt, 0);
        check("p1_busy", busy_o, 0);

        // Zero-length header, then single-byte payload
        clear_mon();
        send(8'hA0); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        check("p2_hdr0", hdr_cnt, 1);
        check("p2_len0", length_o, 0);
        check("p2_busy0", busy_o, 0);
        check("p2_nb0", beats.size(), 0);
        send(8'hA1); send(8'h00); send(8'h01); send(8'h00); send(8'h5A);
        idle(3);
        check("p2_hdr1", hdr_cnt, 2);
        check("p2_op1", mon_op, 8'hA1);
        check("p2_len1", mon_len, 1);
        check("p2_nb1", beats.size(), 1);
        if (beats.size() == 1) check("p2_b0", beats[0], 9'h15A);

        // Bad opcode drains, next packet decodes
        clear_mon();
        send(8'h7F); send(8'h00); send(8'h02); send(8'h00);
        check("p3_err_pulse", err_o, 1);
        check("p3_code", err_code_o, 1);
        send(8'hAA); send(8'hBB);
        check("p3_busy", busy_o, 0);
        send(8'hEC); send(8'h00); send(8'h01); send(8'h00); send(8'hCC);
        idle(3);
        check("p3_hdr", hdr_cnt, 1);
        check("p3_errcnt", err_cnt, 1);
        check("p3_nb", beats.size(), 1);
        if (beats.size() == 1) check("p3_b0", beats[0], 9'h1CC);

        // Oversize length drains 17 bytes
        clear_mon();
        send(8'hEC); send(8'h00); send(8'h11); send(8'h00);
        check("p4_code", err_code_o, 2);
        for (int i = 0; i < 16; i++) send(8'(i));
        check("p4_busy16", busy_o, 1);
        send(8'h55);
        check("p4_busy17", busy_o, 0);
        idle(2);
        check("p4_hdr", hdr_cnt, 0);
        check("p4_errcnt", err_cnt, 1);
        check("p4_nb", beats.size(), 0);

        // Max length accepted
        clear_mon();
        send(8'hA2); send(8'h00); send(8'h10); send(8'h00);
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
        idle(3);
        check("p5_hdr", hdr_cnt, 1);
        check("p5_nb", beats.size(), 16);
        if (beats.size() == 16) check("p5_blast", beats[15], 9'h14F);

        // Overrun with stalled downstream
        clear_mon();
        pld_ready_i = 1'b0;
        send(8'hEC); send(8'h00); send(8'h02); send(8'h00); send(8'h01);
        check("p6_pvalid", pld_valid_o, 1);
        check("p6_pdata", pld_data_o, 8'h01);
        send(8'h02);
        check("p6_err", err_o, 1);
        check("p6_code", err_code_o, 3);
        check("p6_busy", busy_o, 0);
        check("p6_hold", pld_data_o, 8'h01);
        pld_ready_i = 1'b1;
        idle(3);
        check("p6_nb", beats.size(), 1);
        if (beats.size() == 1) check("p6_b0", beats[0], 9'h001);

        // Asynchronous reset mid-payload
        pld_ready_i = 1'b0;
        send(8'hEC); send(8'h00); send(8'h03); send(8'h00); send(8'h11);
        rst_i = 1'b0;
        #1;
        check("r_pvalid", pld_valid_o, 0);
        check("r_busy", busy_o, 0);
        check("r_op", opcode_o, 0);
        check("r_len", length_o, 0);
        check("r_pdata", pld_data_o, 0);
        idle(1);
        rst_i = 1'b1;
        pld_ready_i = 1'b1;
        idle(1);

`ifdef UART_PKT_TIMEOUT_EN
        begin
            int n;
            clear_mon();
            send(8'hEC); send(8'h00);
            n = 0;
            while (!err_o && n < 7000) begin
                idle(1);
                n = n + 1;
            end
            check("to_seen", err_o, 1);
            check("to_code", err_code_o, 0);
            check("to_busy", busy_o, 0);
            check("to_early", (n >= 5500) ? 1 : 0, 1);
        end
`endif

        check("never_both", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Receive-side framer inside uart_alu, between the UART byte receiver and the ALU/echo datapath.
- Consumes the byte stream a host sends (opcode, reserved, length LSB, length MSB, payload) and decodes the 4-byte header.
- Presents the header once, then streams payload bytes with valid/ready and a last flag.
- Rejects unknown opcodes and oversize lengths by draining the packet and raising an error pulse.

Parameters:
- MaxLen, 16, largest accepted payload length in bytes; larger lengths are errors.
- LenW, 16, width of the length field and internal byte counter.
- TimeoutCycles, 5560, idle clocks allowed between bytes inside a packet (about 4 byte times at 16 MHz / 115200 baud); used only with the optional feature.

Ports:
- clk_i  in  1  system clock, 16 MHz nominal
- rst_i  in  1  asynchronous, active-low reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe per received byte; cannot be stalled
- hdr_valid_o  out  1  one-cycle pulse when a valid header is decoded
- opcode_o  out  8  opcode; held until the next hdr_valid_o
- length_o  out  LenW  payload byte count; held until the next hdr_valid_o
- pld_data_o  out  8  payload byte
- pld_valid_o  out  1  payload byte available
- pld_ready_i  in  1  downstream accepts the payload byte
- pld_last_o  out  1  qualifies pld_data_o as the final payload byte
- busy_o  out  1  high in any state other than S_OPCODE
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  error cause, held until the next err_o: 1 = bad opcode, 2 = length > MaxLen, 3 = payload overrun

Behaviour:
- Reset (rst_i = 0, asynchronous): state S_OPCODE; all outputs, the counter and the output register are 0.
- Bytes are consumed only on cycles with rx_valid_i = 1.
- States and transitions:
  - S_OPCODE: latch the byte as the opcode, go to S_RSVD.
  - S_RSVD: ignore the byte value, go to S_LEN_LO.
  - S_LEN_LO: latch the length LSB, go to S_LEN_HI.
  - S_LEN_HI: latch the length MSB, then evaluate, with the bad-opcode check taking priority:
    - Opcode not in the package opcode set: err_o with code 1; go to S_DRAIN if length > 0, else S_OPCODE.
    - Length > MaxLen: err_o with code 2; go to S_DRAIN.
    - Otherwise: hdr_valid_o pulses the cycle after the LEN_HI byte. Go to S_PAYLOAD, or to S_OPCODE if length = 0 (header only, no payload beats).
  - S_PAYLOAD: each byte loads the 1-entry output register and decrements the counter. The last byte sets pld_last_o and returns to S_OPCODE.
  - S_DRAIN: discard bytes, decrement the counter, return to S_OPCODE when it reaches 0.
- Payload latency: pld_valid_o rises the cycle after rx_valid_i.
- Payload handshake:
  - pld_valid_o holds until pld_valid_o && pld_ready_i; pld_data_o and pld_last_o are stable while pld_valid_o = 1.
  - A new byte arriving on the same cycle as the handshake loads the register with no bubble.
  - A new byte arriving while the register is full and not handshaking is an overrun: the byte is dropped, err_o pulses with code 3, and the counter still decrements so framing stays aligned.
- Payload length 0 bypasses payload states entirely. Length = MaxLen is accepted.
- The counter is LenW bits and never wraps, because S_DRAIN exits at 0.
- hdr_valid_o and err_o are never high in the same cycle.

Optional Feature:
- Macro: UART_PKT_TIMEOUT_EN.
- When defined: a 16-bit idle counter runs while busy_o = 1 and clears on every rx_valid_i. On reaching TimeoutCycles:
  - return to S_OPCODE;
  - clear pld_valid_o;
  - pulse err_o with code 0 (timeout).
- When undefined: no counter exists, the parser waits indefinitely, and code 0 is never produced.

Decomposition:
- Package uart_pkt_pkg holds:
  - state enum pkt_state_e;
  - opcode localparams: OP_ECHO 8'hEC, OP_ADD 8'hA0, OP_MUL 8'hA1, OP_DIV 8'hA2;
  - err_code_e;
  - function opcode_valid().
- One natural sub-module: pkt_out_reg, the 1-entry valid/ready holding register with overrun detection. Everything else stays in uart_pkt_parser.

Test Plan:
- Bytes EC 00 03 00 11 22 33, ready held 1 -> hdr_valid_o with opcode 8'hEC and length 3; payload 11, 22, 33; pld_last_o only on 33; err_o never.
- Bytes A0 00 00 00, then A1 00 01 00 5A -> first packet gives hdr_valid_o with length 0 and no payload beats; second gives a header plus a single beat 5A with last = 1.
- Bytes 7F 00 02 00 AA BB, then EC 00 01 00 CC -> err_o with code 1 and no hdr_valid_o; AA and BB drained; next packet decoded normally with payload CC.
- Bytes EC 00 11 00 followed by 17 bytes (length 17 > MaxLen) -> err_o with code 2; all 17 drained; busy_o falls after the 17th byte.
- Bytes EC 00 02 00 01 02 with pld_ready_i = 0 -> payload 01 is held; on byte 02, err_o with code 3; parser returns to S_OPCODE.
- Assert reset mid-payload, and separately (with UART_PKT_TIMEOUT_EN) stop after EC 00 -> reset clears all outputs at once; timeout gives err_o with code 0 after 5560 cycles and busy_o = 0.
